// File: rtl/ctrl_seq_ula.sv
// Multi-cycle sequencer driving a shared 8-bit ALU: 8x8 shift-add MUL and
// two-pass ADD16, with valid/ready handshakes on both request and result sides.
module ctrl_seq_ula #(
  parameter logic [3:0] ADD_S  = 4'b1001,
  parameter logic [3:0] IDLE_S = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic        out_cout,
  output logic [7:0]  ula_a,
  output logic [7:0]  ula_b,
  output logic [3:0]  ula_s,
  output logic        ula_m,
  output logic        ula_c_in,
  input  logic [7:0]  ula_f,
  input  logic        ula_c_out
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_ADDL = 3'd2;
  localparam logic [2:0] ST_ADDH = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_x;      // r_x[7:0] doubles as the multiplicand
  logic [15:0] r_y;
  logic [7:0]  r_acc;
  logic [7:0]  r_q;
  logic [2:0]  r_count;
  logic        r_carry;
  logic [15:0] r_res;
  logic        r_cout;

  logic [7:0]  w_acc_next;
  logic [7:0]  w_q_next;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_res   = r_res;
  assign out_cout  = r_cout;

  // The 9-bit {c_out,f} sum shifted right one place: its LSB becomes the
  // next product bit entering q from the top.
  assign w_acc_next = {ula_c_out, ula_f[7:1]};
  assign w_q_next   = {ula_f[0], r_q[7:1]};

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ula_a    = 8'h00;
    ula_b    = 8'h00;
    ula_s    = IDLE_S;
    ula_m    = 1'b1;
    ula_c_in = 1'b0;
    case (r_state)
      ST_MUL: begin
        ula_a = r_acc;
        ula_b = r_q[0] ? r_x[7:0] : 8'h00;
        ula_s = ADD_S;
        ula_m = 1'b0;
      end
      ST_ADDL: begin
        ula_a = r_x[7:0];
        ula_b = r_y[7:0];
        ula_s = ADD_S;
        ula_m = 1'b0;
      end
      ST_ADDH: begin
        ula_a    = r_x[15:8];
        ula_b    = r_y[15:8];
        ula_c_in = r_carry;
        ula_s    = ADD_S;
        ula_m    = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset clears all state, discarding any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x     <= in_x;
            r_y     <= in_y;
            r_q     <= in_y[7:0];
            r_acc   <= 8'h00;
            r_count <= 3'd0;
            r_state <= in_op ? ST_ADDL : ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc   <= w_acc_next;
          r_q     <= w_q_next;
          r_count <= r_count + 3'd1;
          if (r_count == 3'd7) begin
            r_res   <= {w_acc_next, w_q_next};
            r_cout  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_ADDL: begin
          r_res[7:0] <= ula_f;
          r_carry    <= ula_c_out;
          r_state    <= ST_ADDH;
        end
        ST_ADDH: begin
          r_res[15:8] <= ula_f;
          r_cout      <= ula_c_out;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
